// File: rtl/sram_req_sequencer_if.sv
// Handshake and SRAM pin bundle shared by the requester, the sequencer and the I/O stage.
// The slave modport is the sequencer's view; the master modport is the requester/I/O side.
interface sram_req_sequencer_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [1:0]        req_be;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] ADDR;
   logic              CE;
   logic              OE;
   logic              WE;
   logic              UB;
   logic              LB;
   logic [DATA_W-1:0] Data_from_CPU;
   logic [DATA_W-1:0] Data_to_CPU;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, Data_to_CPU,
      output req_ready, rsp_valid, rsp_rdata, ADDR, CE, OE, WE, UB, LB, Data_from_CPU
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, Data_to_CPU,
      input  req_ready, rsp_valid, rsp_rdata, ADDR, CE, OE, WE, UB, LB, Data_from_CPU
   );
endinterface

// File: rtl/sram_req_sequencer.sv
// Single-word SRAM request sequencer: accepts valid/ready requests, drives active-low
// strobes with programmable wait states and returns a one-cycle response pulse.
//
// state   | meaning
// S_IDLE  | strobes high, req_ready asserted, waiting for a request
// S_READ  | CE/OE low with byte enables for RD_WAIT cycles
// S_WRITE | CE/WE low with byte enables for WR_WAIT cycles
// S_TURN  | bus idle for TURN cycles before the next access
module sram_req_sequencer #(
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 16,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2,
   parameter int TURN    = 1
) (
   input  logic                Clk,
   input  logic                Reset,
   sram_req_sequencer_if.slave bus
);

   localparam int MAX_A    = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int MAX_B    = (MAX_A > TURN) ? MAX_A : TURN;
   localparam int MAX_LOAD = (MAX_B > 1) ? MAX_B : 1;
   localparam int CNT_W    = $clog2(MAX_LOAD + 1);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
   localparam logic [CNT_W-1:0] TN_LOAD = CNT_W'((TURN > 0) ? TURN - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_TURN  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       be_q;
   logic [1:0]       be_d;
   logic             accept;
   logic             done;
   logic             ce_d;
   logic             oe_d;
   logic             we_d;
   logic             ub_d;
   logic             lb_d;

   assign bus.req_ready = (state_q == S_IDLE) && !Reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               state_d = bus.req_we ? S_WRITE : S_READ;
               cnt_d   = bus.req_we ? WR_LOAD : RD_LOAD;
            end
         end
         S_READ, S_WRITE: begin
            // cnt_q reaching zero marks the final strobe cycle
            if (cnt_q == '0) begin
               done = 1'b1;
               if (TURN == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_TURN;
                  cnt_d   = TN_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_TURN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // strobes are registered from the state being entered
      be_d = accept ? bus.req_be : be_q;
      ce_d = 1'b1;
      oe_d = 1'b1;
      we_d = 1'b1;
      ub_d = 1'b1;
      lb_d = 1'b1;
      case (state_d)
         S_READ: begin
            ce_d = 1'b0;
            oe_d = 1'b0;
            ub_d = ~be_d[1];
            lb_d = ~be_d[0];
         end
         S_WRITE: begin
            ce_d = 1'b0;
            we_d = 1'b0;
            ub_d = ~be_d[1];
            lb_d = ~be_d[0];
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q           <= S_IDLE;
         cnt_q             <= '0;
         be_q              <= 2'b00;
         bus.ADDR          <= {ADDR_W{1'b0}};
         bus.Data_from_CPU <= {DATA_W{1'b0}};
         bus.CE            <= 1'b1;
         bus.OE            <= 1'b1;
         bus.WE            <= 1'b1;
         bus.UB            <= 1'b1;
         bus.LB            <= 1'b1;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_rdata     <= {DATA_W{1'b0}};
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         be_q          <= be_d;
         bus.CE        <= ce_d;
         bus.OE        <= oe_d;
         bus.WE        <= we_d;
         bus.UB        <= ub_d;
         bus.LB        <= lb_d;
         bus.rsp_valid <= done;
         if (done && (state_q == S_READ)) begin
            bus.rsp_rdata <= bus.Data_to_CPU;
         end
         if (accept) begin
            bus.ADDR          <= bus.req_addr;
            bus.Data_from_CPU <= bus.req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Bench for sram_req_sequencer: two instances (default timing and RD_WAIT=1/TURN=0)
// compared every cycle against a transaction-phase model of the request sequencer.
module tb_sram_req_sequencer;
   localparam int AW = 20;
   localparam int DW = 16;

   int p_rd [2] = '{2, 1};
   int p_wr [2] = '{2, 2};
   int p_tn [2] = '{1, 0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_req_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
   sram_req_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

   sram_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(2), .WR_WAIT(2), .TURN(1)) dut_a (
      .Clk(clk), .Reset(rst), .bus(ifa));
   sram_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1), .WR_WAIT(2), .TURN(0)) dut_b (
      .Clk(clk), .Reset(rst), .bus(ifb));

   logic          v_valid [2];
   logic          v_we    [2];
   logic [AW-1:0] v_addr  [2];
   logic [DW-1:0] v_wdata [2];
   logic [1:0]    v_be    [2];
   logic [DW-1:0] v_dtc   [2];

   logic          o_ready [2];
   logic          o_rsp   [2];
   logic [DW-1:0] o_rd    [2];
   logic [AW-1:0] o_addr  [2];
   logic [DW-1:0] o_dfc   [2];
   logic          o_ce    [2];
   logic          o_oe    [2];
   logic          o_we    [2];
   logic          o_ub    [2];
   logic          o_lb    [2];

   assign ifa.req_valid   = v_valid[0];
   assign ifa.req_we      = v_we[0];
   assign ifa.req_addr    = v_addr[0];
   assign ifa.req_wdata   = v_wdata[0];
   assign ifa.req_be      = v_be[0];
   assign ifa.Data_to_CPU = v_dtc[0];
   assign ifb.req_valid   = v_valid[1];
   assign ifb.req_we      = v_we[1];
   assign ifb.req_addr    = v_addr[1];
   assign ifb.req_wdata   = v_wdata[1];
   assign ifb.req_be      = v_be[1];
   assign ifb.Data_to_CPU = v_dtc[1];

   assign o_ready[0] = ifa.req_ready;
   assign o_rsp[0]   = ifa.rsp_valid;
   assign o_rd[0]    = ifa.rsp_rdata;
   assign o_addr[0]  = ifa.ADDR;
   assign o_dfc[0]   = ifa.Data_from_CPU;
   assign o_ce[0]    = ifa.CE;
   assign o_oe[0]    = ifa.OE;
   assign o_we[0]    = ifa.WE;
   assign o_ub[0]    = ifa.UB;
   assign o_lb[0]    = ifa.LB;
   assign o_ready[1] = ifb.req_ready;
   assign o_rsp[1]   = ifb.rsp_valid;
   assign o_rd[1]    = ifb.rsp_rdata;
   assign o_addr[1]  = ifb.ADDR;
   assign o_dfc[1]   = ifb.Data_from_CPU;
   assign o_ce[1]    = ifb.CE;
   assign o_oe[1]    = ifb.OE;
   assign o_we[1]    = ifb.WE;
   assign o_ub[1]    = ifb.UB;
   assign o_lb[1]    = ifb.LB;

   // model: k counts cycles since the accept edge (1 = first strobe cycle)
   bit            has      [2];
   int            k        [2];
   bit            mwe      [2];
   logic [AW-1:0] maddr    [2];
   logic [DW-1:0] mwd      [2];
   logic [DW-1:0] mrd      [2];
   logic [1:0]    mbe      [2];
   bit            acc_flag [2];
   int            dacc_edge[2];
   int            rsp_seen [2];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   bit rand_dtc = 1'b0;

   task automatic check(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL d%0d_%s observed=%h expected=%h cycle=%0d", d, tag, obs, exp, cyc);
      end
   endtask

   task automatic model_update(input int d);
      int w;
      bit rdy;
      w = mwe[d] ? p_wr[d] : p_rd[d];
      if (rst) begin
         has[d]   = 1'b0;
         k[d]     = 0;
         maddr[d] = '0;
         mwd[d]   = '0;
         mrd[d]   = '0;
      end else begin
         rdy = !has[d] || (k[d] >= w + p_tn[d] + 1);
         if (rdy && v_valid[d] === 1'b1) begin
            has[d]      = 1'b1;
            k[d]        = 1;
            mwe[d]      = v_we[d];
            maddr[d]    = v_addr[d];
            mwd[d]      = v_wdata[d];
            mbe[d]      = v_be[d];
            acc_flag[d] = 1'b1;
         end else if (has[d]) begin
            if (!mwe[d] && k[d] == w) mrd[d] = v_dtc[d];
            if (k[d] < 1000) k[d]++;
         end
      end
   endtask

   task automatic compare(input int d);
      int w;
      bit act;
      bit rdy;
      w   = mwe[d] ? p_wr[d] : p_rd[d];
      act = has[d] && (k[d] <= w);
      rdy = !rst && (!has[d] || (k[d] >= w + p_tn[d] + 1));
      check(d, "req_ready", o_ready[d], rdy);
      check(d, "CE", o_ce[d], !act);
      check(d, "OE", o_oe[d], !(act && !mwe[d]));
      check(d, "WE", o_we[d], !(act && mwe[d]));
      check(d, "UB", o_ub[d], !(act && mbe[d][1]));
      check(d, "LB", o_lb[d], !(act && mbe[d][0]));
      check(d, "ADDR", o_addr[d], maddr[d]);
      check(d, "Data_from_CPU", o_dfc[d], mwd[d]);
      check(d, "rsp_valid", o_rsp[d], has[d] && (k[d] == w + 1));
      check(d, "rsp_rdata", o_rd[d], mrd[d]);
      check(d, "oe_we_excl", o_oe[d] | o_we[d], 1'b1);
   endtask

   task automatic step();
      bit dut_acc [2];
      for (int d = 0; d < 2; d++) begin
         if (rand_dtc) v_dtc[d] = DW'($urandom);
         dut_acc[d] = (o_ready[d] === 1'b1) && (v_valid[d] === 1'b1);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (dut_acc[d] && !rst) dacc_edge[d] = cyc;
         model_update(d);
         compare(d);
         if (o_rsp[d] === 1'b1) rsp_seen[d]++;
      end
   endtask

   task automatic idle(input int n);
      v_valid[0] = 1'b0;
      v_valid[1] = 1'b0;
      repeat (n) step();
   endtask

   task automatic issue(input int d, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [1:0] be);
      bit done;
      done        = 1'b0;
      v_we[d]     = we;
      v_addr[d]   = a;
      v_wdata[d]  = wd;
      v_be[d]     = be;
      v_valid[d]  = 1'b1;
      acc_flag[d] = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         done = acc_flag[d];
      end
      check(d, "accept_timeout", acc_flag[d], 1'b1);
   endtask

   initial begin
      int e1;
      int e2;
      for (int d = 0; d < 2; d++) begin
         v_valid[d] = 1'b0;
         v_we[d]    = 1'b0;
         v_addr[d]  = '0;
         v_wdata[d] = '0;
         v_be[d]    = 2'b00;
         v_dtc[d]   = '0;
         has[d]     = 1'b0;
         k[d]       = 0;
         mwe[d]     = 1'b0;
         maddr[d]   = '0;
         mwd[d]     = '0;
         mrd[d]     = '0;
         mbe[d]     = 2'b00;
         dacc_edge[d] = -1;
         rsp_seen[d]  = 0;
      end

      // reset held for two cycles, req_ready low throughout
      rst = 1'b1;
      step();
      step();
      check(0, "rst_ready", o_ready[0], 1'b0);
      rst = 1'b0;
      #1;
      check(0, "post_rst_ready", o_ready[0], 1'b1);
      step();

      // read with both bytes, I/O stage returns BEEF
      v_dtc[0] = 16'hBEEF;
      issue(0, 1'b0, 20'h00123, 16'h1111, 2'b11);
      check(0, "rd_strobes", {o_ce[0], o_oe[0], o_ub[0], o_lb[0], o_we[0]}, 5'b00001);
      step();
      step();
      check(0, "rd_rsp", o_rsp[0], 1'b1);
      check(0, "rd_beef", o_rd[0], 16'hBEEF);
      idle(2);

      // write, lower byte only, to the top address
      issue(0, 1'b1, 20'hFFFFF, 16'h00A5, 2'b01);
      check(0, "wr_strobes", {o_we[0], o_lb[0], o_ub[0], o_oe[0]}, 4'b0011);
      check(0, "wr_dfc", o_dfc[0], 16'h00A5);
      idle(4);
      check(0, "wr_rdata_kept", o_rd[0], 16'hBEEF);

      // back-to-back write then read with req_valid held high
      dacc_edge[0] = -1;
      issue(0, 1'b1, 20'h0ABCD, 16'h5A5A, 2'b10);
      e1 = dacc_edge[0];
      v_dtc[0] = 16'h1234;
      issue(0, 1'b0, 20'h0ABCE, 16'h0000, 2'b11);
      e2 = dacc_edge[0];
      check(0, "b2b_gap", e2 - e1, 1 + p_wr[0] + p_tn[0]);
      idle(5);

      // reset during the first read cycle drops the access
      issue(0, 1'b0, 20'h00777, 16'hCAFE, 2'b11);
      v_valid[0]  = 1'b0;
      rst         = 1'b1;
      rsp_seen[0] = 0;
      step();
      rst = 1'b0;
      idle(6);
      check(0, "midrst_no_rsp", rsp_seen[0], 0);

      // short-timing instance: one strobe cycle, response and ready together
      v_dtc[1] = 16'h7E57;
      issue(1, 1'b0, 20'h00042, 16'h0000, 2'b11);
      check(1, "short_ce", o_ce[1], 1'b0);
      idle(1);
      check(1, "short_rsp", o_rsp[1], 1'b1);
      check(1, "short_ready", o_ready[1], 1'b1);
      check(1, "short_rdata", o_rd[1], 16'h7E57);
      idle(2);

      // randomized traffic on both instances, including be=00 requests
      rand_dtc = 1'b1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 2));
            issue(d, 1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom));
         end
         idle(6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
